// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types, constants and column/row shift helper for the 3x3 window buffer
package sobel_pkg;

  localparam int WIN_PIX = 9;
  localparam int PIX_W   = 8;

  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL9 = 2'd1,
    ST_FILL3 = 2'd2
  } state_e;

  // Slide the window one step in 'dir' and insert 'line' (entry k at bits [8k+7:8k]) on the exposed edge.
  function automatic logic [WIN_PIX*PIX_W-1:0] shift_in(
    input logic [WIN_PIX*PIX_W-1:0] win,
    input logic [3*PIX_W-1:0]       line,
    input logic [1:0]               dir
  );
    logic [WIN_PIX*PIX_W-1:0] res;
    res = win;
    case (dir)
      DIR_RIGHT: begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 0; c < 2; c++) begin
            res[PIX_W*(3*r+c) +: PIX_W] = win[PIX_W*(3*r+c+1) +: PIX_W];
          end
          res[PIX_W*(3*r+2) +: PIX_W] = line[PIX_W*r +: PIX_W];
        end
      end
      DIR_LEFT: begin
        for (int r = 0; r < 3; r++) begin
          for (int c = 1; c < 3; c++) begin
            res[PIX_W*(3*r+c) +: PIX_W] = win[PIX_W*(3*r+c-1) +: PIX_W];
          end
          res[PIX_W*(3*r) +: PIX_W] = line[PIX_W*r +: PIX_W];
        end
      end
      DIR_DOWN: begin
        for (int r = 0; r < 2; r++) begin
          for (int c = 0; c < 3; c++) begin
            res[PIX_W*(3*r+c) +: PIX_W] = win[PIX_W*(3*(r+1)+c) +: PIX_W];
          end
        end
        for (int c = 0; c < 3; c++) begin
          res[PIX_W*(6+c) +: PIX_W] = line[PIX_W*c +: PIX_W];
        end
      end
      default: res = win;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/window_buffer_if.sv
// rtl/window_buffer_if.sv - load-control, pixel stream and window output bundle
interface window_buffer_if;
  import sobel_pkg::*;

  logic                       start_fill9;
  logic                       start_fill3;
  logic [1:0]                 direction;
  logic [PIX_W-1:0]           pixel_in;
  logic                       pixel_valid;
  logic                       abort;
  logic [WIN_PIX*PIX_W-1:0]   window;
  logic                       window_valid;
  logic                       busy;
  logic                       err;

  modport master (
    output start_fill9, start_fill3, direction, pixel_in, pixel_valid, abort,
    input  window, window_valid, busy, err
  );

  modport slave (
    input  start_fill9, start_fill3, direction, pixel_in, pixel_valid, abort,
    output window, window_valid, busy, err
  );

endinterface

// File: rtl/window_buffer.sv
// rtl/window_buffer.sv - 3x3 pixel window with full 9-pixel load and 3-pixel slide loads
// Optional sticky protocol-error flag is built when WINBUF_ERR_EN is defined.
module window_buffer
  import sobel_pkg::*;
(
  input logic            clk,
  input logic            n_reset,
  window_buffer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_FILL9 = ST_FILL9;
  localparam logic [1:0] S_FILL3 = ST_FILL3;

  logic [1:0]               state_q,  state_d;
  logic [3:0]               count_q,  count_d;
  logic [1:0]               dir_q,    dir_d;
  logic [3*PIX_W-1:0]       shadow_q, shadow_d;
  logic [WIN_PIX*PIX_W-1:0] window_q, window_d;
  logic                     valid_q,  valid_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dir_d    = dir_q;
    shadow_d = shadow_q;
    window_d = window_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start_fill9) begin
          state_d = S_FILL9;
          count_d = 4'd0;
        end else if (bus.start_fill3 && (bus.direction != DIR_NONE)) begin
          state_d  = S_FILL3;
          count_d  = 4'd0;
          dir_d    = bus.direction;
          shadow_d = '0;
        end
      end
      S_FILL9: begin
        if (bus.abort) begin
          state_d  = S_IDLE;
          count_d  = 4'd0;
          shadow_d = '0;
        end else if (bus.pixel_valid) begin
          window_d[PIX_W*int'(count_q) +: PIX_W] = bus.pixel_in;
          if (count_q == 4'(WIN_PIX-1)) begin
            state_d = S_IDLE;
            valid_d = 1'b1;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end
      S_FILL3: begin
        if (bus.abort) begin
          state_d  = S_IDLE;
          count_d  = 4'd0;
          shadow_d = '0;
        end else if (bus.pixel_valid) begin
          // Third pixel bypasses the shadow and lands with the other two in one update.
          if (count_q == 4'd2) begin
            window_d = shift_in(window_q, {bus.pixel_in, shadow_q[2*PIX_W-1:0]}, dir_q);
            state_d  = S_IDLE;
            valid_d  = 1'b1;
          end else begin
            shadow_d[PIX_W*int'(count_q) +: PIX_W] = bus.pixel_in;
            count_d = count_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= S_IDLE;
      count_q  <= 4'd0;
      dir_q    <= 2'b00;
      shadow_q <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dir_q    <= dir_d;
      shadow_q <= shadow_d;
      window_q <= window_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.window       = window_q;
  assign bus.window_valid = valid_q;
  assign bus.busy         = (state_q != S_IDLE);

`ifdef WINBUF_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = ((state_q == S_IDLE) &&
                    (bus.pixel_valid ||
                     (!bus.start_fill9 && bus.start_fill3 && (bus.direction == DIR_NONE)))) ||
                   ((state_q != S_IDLE) && (bus.start_fill9 || bus.start_fill3));

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_window_buffer.sv
// tb/tb_window_buffer.sv - directed and randomized bench for window_buffer against a transaction-level model
module tb_window_buffer;
  import sobel_pkg::*;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  window_buffer_if bif();

  window_buffer dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bif.slave)
  );

  localparam logic [71:0] BASE  = 72'h090807060504030201;
  localparam logic [71:0] RIGHT = 72'h0C09080B06050A0302;
  localparam logic [71:0] LEFT  = 72'h080716050415020114;
  localparam logic [71:0] DOWN  = 72'h201F1E090807060504;

  int total = 0;
  int bad   = 0;

  // Model: window as a 3x3 array, pending load as a queue of accepted pixels.
  int mw [3][3];
  int mode;
  int mdir;
  int q [$];
  bit mvalid;
  bit merr;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] model_window();
    logic [71:0] res;
    res = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        res[8*(3*r+c) +: 8] = 8'(mw[r][c]);
    return res;
  endfunction

  task automatic mreset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        mw[r][c] = 0;
    mode   = 0;
    mdir   = 0;
    q.delete();
    mvalid = 1'b0;
    merr   = 1'b0;
  endtask

  task automatic mstep(input bit sf9, input bit sf3, input logic [1:0] dir,
                       input bit pv, input logic [7:0] pix, input bit ab);
    int t [3][3];
    int k;
    mvalid = 1'b0;
    if (mode == 0) begin
      if (pv) merr = 1'b1;
      if (sf9) begin
        mode = 1;
        q.delete();
      end else if (sf3) begin
        if (dir != 2'b00) begin
          mode = 2;
          mdir = int'(dir);
          q.delete();
        end else begin
          merr = 1'b1;
        end
      end
    end else begin
      if (sf9 || sf3) merr = 1'b1;
      if (ab) begin
        mode = 0;
        q.delete();
      end else if (pv) begin
        q.push_back(int'(pix));
        if (mode == 1) begin
          k = q.size() - 1;
          mw[k/3][k%3] = int'(pix);
          if (q.size() == 9) begin
            mode   = 0;
            mvalid = 1'b1;
          end
        end else if (q.size() == 3) begin
          t = mw;
          for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
              if (mdir == 1)      mw[r][c] = (c < 2) ? t[r][(c+1)%3] : q[r];
              else if (mdir == 2) mw[r][c] = (c > 0) ? t[r][(c+2)%3] : q[r];
              else                mw[r][c] = (r < 2) ? t[(r+1)%3][c] : q[c];
            end
          end
          mode   = 0;
          mvalid = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input bit sf9, input bit sf3, input logic [1:0] dir,
                       input bit pv, input logic [7:0] pix, input bit ab);
    bit exp_err;
    bif.start_fill9 = sf9;
    bif.start_fill3 = sf3;
    bif.direction   = dir;
    bif.pixel_valid = pv;
    bif.pixel_in    = pix;
    bif.abort       = ab;
    @(posedge clk);
    mstep(sf9, sf3, dir, pv, pix, ab);
    #1;
`ifdef WINBUF_ERR_EN
    exp_err = merr;
`else
    exp_err = 1'b0;
`endif
    check("window", bif.window, model_window());
    check("window_valid", 72'(bif.window_valid), 72'(mvalid));
    check("busy", 72'(bif.busy), 72'(mode != 0));
    check("err", 72'(bif.err), 72'(exp_err));
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic fill9_base();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 9; i++) drive(1'b0, 1'b0, 2'b00, 1'b1, 8'(i), 1'b0);
    check("fill9_rows", bif.window, BASE);
    check("fill9_pulse", 72'(bif.window_valid), 72'd1);
    idle();
    check("fill9_pulse_end", 72'(bif.window_valid), 72'd0);
  endtask

  task automatic fill3(input logic [1:0] dir, input int a, input int b, input int c,
                       input logic [71:0] exp, input string tag);
    drive(1'b0, 1'b1, dir, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 8'(a), 1'b0);
    check({tag, "_hold1"}, bif.window, BASE);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 8'(b), 1'b0);
    check({tag, "_hold2"}, bif.window, BASE);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 8'(c), 1'b0);
    check({tag, "_rows"}, bif.window, exp);
    check({tag, "_pulse"}, 72'(bif.window_valid), 72'd1);
    idle();
  endtask

  initial begin
    bif.start_fill9 = 1'b0;
    bif.start_fill3 = 1'b0;
    bif.direction   = 2'b00;
    bif.pixel_in    = 8'h00;
    bif.pixel_valid = 1'b0;
    bif.abort       = 1'b0;
    n_reset = 1'b0;
    mreset();
    #3;
    check("rst_window", bif.window, 72'd0);
    check("rst_valid", 72'(bif.window_valid), 72'd0);
    check("rst_busy", 72'(bif.busy), 72'd0);
    check("rst_err", 72'(bif.err), 72'd0);
    @(posedge clk);
    #1 n_reset = 1'b1;

    fill9_base();
    fill3(2'b01, 10, 11, 12, RIGHT, "right");
    fill9_base();
    fill3(2'b10, 20, 21, 22, LEFT, "left");
    fill9_base();
    fill3(2'b11, 30, 31, 32, DOWN, "down");

    // Gapped FILL3: pixels only on cycles 1, 4 and 9 of the load.
    fill9_base();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      if (cyc == 1)      drive(1'b0, 1'b0, 2'b00, 1'b1, 8'd10, 1'b0);
      else if (cyc == 4) drive(1'b0, 1'b0, 2'b00, 1'b1, 8'd11, 1'b0);
      else if (cyc == 9) drive(1'b0, 1'b0, 2'b00, 1'b1, 8'd12, 1'b0);
      else               idle();
    end
    check("gap_rows", bif.window, RIGHT);
    idle();

    // Abort after two of three pixels, then a clean slide.
    fill9_base();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 8'd10, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 8'd11, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 8'd99, 1'b1);
    check("abort_window", bif.window, BASE);
    check("abort_nopulse", 72'(bif.window_valid), 72'd0);
    check("abort_idle", 72'(bif.busy), 72'd0);
    idle();
    fill3(2'b01, 10, 11, 12, RIGHT, "post_abort");

    // Reset mid-FILL9, then a stray pixel in IDLE.
    drive(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, 1'b0);
    for (int i = 1; i <= 4; i++) drive(1'b0, 1'b0, 2'b00, 1'b1, 8'(40 + i), 1'b0);
    n_reset = 1'b0;
    #2;
    mreset();
    check("midrst_window", bif.window, 72'd0);
    check("midrst_busy", 72'(bif.busy), 72'd0);
    check("midrst_valid", 72'(bif.window_valid), 72'd0);
    #2 n_reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 1'b1, 8'h55, 1'b0);
    check("stray_window", bif.window, 72'd0);
    check("stray_nopulse", 72'(bif.window_valid), 72'd0);
`ifdef WINBUF_ERR_EN
    check("stray_err", 72'(bif.err), 72'd1);
`else
    check("stray_err", 72'(bif.err), 72'd0);
`endif

    // Randomized traffic: sparse starts, dense pixels, occasional aborts.
    for (int n = 0; n < 1500; n++) begin
      bit sf9, sf3, pv, ab;
      sf9 = ($urandom_range(0, 15) == 0);
      sf3 = ($urandom_range(0, 7) == 0);
      pv  = ($urandom_range(0, 2) != 0);
      ab  = ($urandom_range(0, 39) == 0);
      drive(sf9, sf3, 2'($urandom_range(0, 3)), pv, 8'($urandom), ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_buffer.md
WINDOW_BUFFER -- requirements
Module: window_buffer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have: n_reset  in  1  asynchronous active-low reset.
REQ-003 SHALL have: start_fill9  in  1  begin 9-pixel initial window load.
REQ-004 SHALL have: start_fill3  in  1  begin 3-pixel incremental load.
REQ-005 SHALL have: direction  in  2  01 right, 10 left, 11 down; sampled on the start_fill3 cycle.
REQ-006 SHALL have: pixel_in  in  8  pixel data from image memory.
REQ-007 SHALL have: pixel_valid  in  1  pixel_in valid this cycle.
REQ-008 SHALL have: abort  in  1  drop current load.
REQ-009 SHALL have: window  out  72  3x3 window, pixel (r,c) at bits [8*(3r+c)+7 : 8*(3r+c)], r and c in 0..2, (0,0) top-left.
REQ-010 SHALL have: window_valid  out  1  one-cycle pulse, window updated.
REQ-011 SHALL have: busy  out  1  load in progress.
REQ-012 SHALL have: err  out  1  sticky protocol-error flag (WINBUF_ERR_EN only).

Function
REQ-013 SHALL implement states IDLE, FILL9, FILL3; busy=1 in FILL9 and FILL3.
REQ-014 IDLE: start_fill9 -> FILL9, count=0; else start_fill3 with direction!=00 -> FILL3, count=0, direction latched; start_fill9 wins if both are asserted.
REQ-015 SHALL ignore start_* while busy.
REQ-016 FILL9: each pixel_valid writes pixel_in into window in row-major order (count 0..8 -> (0,0),(0,1),...,(2,2)), count+1.
REQ-017 FILL9: on the 9th pixel -> IDLE, window_valid=1 the next cycle.
REQ-018 FILL3: pixels go to a 3-entry shadow register; window unchanged until the 3rd pixel.
REQ-019 FILL3 order: right/left = rows 0,1,2 of the new column; down = cols 0,1,2 of the new row.
REQ-020 FILL3, 3rd pixel, right: columns shift left one, shadow -> column 2, in one cycle.
REQ-021 FILL3, 3rd pixel, left: columns shift right one, shadow -> column 0.
REQ-022 FILL3, 3rd pixel, down: rows shift up one, shadow -> row 2.
REQ-023 FILL3: after the 3rd pixel -> IDLE, window_valid=1 the next cycle.
REQ-024 window_valid SHALL be a single-cycle pulse; latency from final pixel_valid = 1 clock.
REQ-025 pixel_valid in IDLE SHALL be ignored; window unchanged.
REQ-026 abort in FILL9/FILL3 SHALL return to IDLE next cycle, clear count and shadow, leave window unchanged, no window_valid; abort has priority over pixel_valid.
REQ-027 count SHALL be 4 bits and saturate at the terminal value (8 or 2); no wrap.
REQ-028 start_fill3 with direction=00 SHALL be ignored (state stays IDLE).

Reset
REQ-029 n_reset low SHALL asynchronously force IDLE, count=0, shadow=0, window=0, window_valid=0, busy=0, err=0.
REQ-030 reset mid-load SHALL discard partial data; no window_valid on release.

Configuration
REQ-031 WINBUF_ERR_EN defined: err sets on pixel_valid in IDLE, start_* while busy, or start_fill3 with direction=00; clears only on reset.
REQ-032 WINBUF_ERR_EN undefined: err tied to 0; no error logic.

Structure
REQ-033 sobel_pkg SHALL hold the direction typedef (DIR_RIGHT=01, DIR_LEFT=10, DIR_DOWN=11), the state enum, and the constants WIN_PIX=9 and PIX_W=8.
REQ-034 single module; no sub-module.

Verification
REQ-035 start_fill9, pixels 1..9 one per cycle -> window rows {1,2,3},{4,5,6},{7,8,9}; window_valid pulse 1 clock after pixel 9.
REQ-036 after REQ-035 state, start_fill3 dir=01, pixels 10,11,12 -> rows {2,3,10},{5,6,11},{8,9,12}; window unchanged after pixels 10 and 11.
REQ-037 after REQ-035 state, dir=10, pixels 20,21,22 -> rows {20,1,2},{21,4,5},{22,7,8}; after REQ-035 state, dir=11, pixels 30,31,32 -> rows {4,5,6},{7,8,9},{30,31,32}.
REQ-038 FILL3 with pixel_valid gaps (valid on cycles 1,4,9) -> same result as contiguous input; busy=1 throughout.
REQ-039 abort after 2 of 3 pixels -> window unchanged, no pulse; a following FILL3 loads correctly.
REQ-040 n_reset low mid-FILL9, then pixel_valid in IDLE -> window=0, no pulse; err=1 only with WINBUF_ERR_EN.
